// File: rtl/adap_sped_seq_if.sv
// Handshake and data bundle for the adaptive speed-control sequencer.
// The master side launches updates, the slave side is the sequencer itself.
interface adap_sped_seq_if;
    logic        START;
    logic [2:0]  FI;
    logic [12:0] Y;
    logic        TDP;
    logic        TR;
    logic [11:0] DMS;
    logic [13:0] DML;
    logic [9:0]  AP;
    logic [6:0]  AL;
    logic        BUSY;
    logic        DONE;

    modport master (
        output START, FI, Y, TDP, TR,
        input  DMS, DML, AP, AL, BUSY, DONE
    );

    modport slave (
        input  START, FI, Y, TDP, TR,
        output DMS, DML, AP, AL, BUSY, DONE
    );
endinterface

// File: rtl/adap_sped_seq.sv
// G.726 adaptation speed control (FILTA/FILTB/SUBTC/FILTC/TRIGA/LIMA) as a
// five-step sequencer; one update per START, results published with DONE.
module adap_sped_seq (
    input  logic               CLK,
    input  logic               RST_N,
    adap_sped_seq_if.slave     bus
);

    typedef enum logic [2:0] {StIdle, StFa, StFb, StSc, StFc, StWb} state_e;

    state_e      state_q, state_d;

    logic [2:0]  fi_q;
    logic [12:0] y_q;
    logic        tdp_q;
    logic        tr_q;

    logic [11:0] dms_q, dms_t_q;
    logic [13:0] dml_q, dml_t_q;
    logic [9:0]  ap_q;
    logic [6:0]  al_q;
    logic        ax_q;

    logic [12:0] dif_s;
    logic [11:0] dms_new;
    logic [14:0] dif_l;
    logic [13:0] dml_new;
    logic [14:0] dif_c;
    logic [14:0] difm;
    logic        ax_new;
    logic [10:0] dif_a;
    logic [9:0]  ap_new;
    logic [6:0]  al_new;

    // The 8192/32768/2048 offsets in the G.726 formulas vanish modulo the word width.
    always_comb begin
        dif_s   = {1'b0, fi_q, 9'd0} - {1'b0, dms_q};
        dms_new = dms_q + {{4{dif_s[12]}}, dif_s[12:5]};

        dif_l   = {1'b0, fi_q, 11'd0} - {1'b0, dml_q};
        dml_new = dml_q + {{6{dif_l[14]}}, dif_l[14:7]};

        dif_c   = {1'b0, dms_t_q, 2'b00} - {1'b0, dml_t_q};
        difm    = dif_c[14] ? (15'd0 - dif_c) : dif_c;
        ax_new  = !((y_q >= 13'd1536) && (difm < {4'd0, dml_t_q[13:3]}) && !tdp_q);

        dif_a   = {1'b0, ax_q, 9'd0} - {1'b0, ap_q};
        ap_new  = tr_q ? 10'd256 : ap_q + {{3{dif_a[10]}}, dif_a[10:4]};
        al_new  = (ap_new >= 10'd256) ? 7'd64 : ap_new[8:2];
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (bus.START) state_d = StFa;
            StFa:    state_d = StFb;
            StFb:    state_d = StSc;
            StSc:    state_d = StFc;
            StFc:    state_d = StWb;
            StWb:    state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Outputs are committed together as WB begins, so DONE and the new values coincide.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            fi_q    <= '0;
            y_q     <= '0;
            tdp_q   <= 1'b0;
            tr_q    <= 1'b0;
            dms_q   <= '0;
            dml_q   <= '0;
            ap_q    <= '0;
            al_q    <= '0;
            dms_t_q <= '0;
            dml_t_q <= '0;
            ax_q    <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.START) begin
                        fi_q  <= bus.FI;
                        y_q   <= bus.Y;
                        tdp_q <= bus.TDP;
                        tr_q  <= bus.TR;
                    end
                end
                StFa: dms_t_q <= dms_new;
                StFb: dml_t_q <= dml_new;
                StSc: ax_q    <= ax_new;
                StFc: begin
                    dms_q <= dms_t_q;
                    dml_q <= dml_t_q;
                    ap_q  <= ap_new;
                    al_q  <= al_new;
                end
                StWb: ;
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.DMS  = dms_q;
        bus.DML  = dml_q;
        bus.AP   = ap_q;
        bus.AL   = al_q;
        bus.BUSY = (state_q != StIdle);
        bus.DONE = (state_q == StWb);
    end

endmodule

// File: tb/tb_adap_sped_seq.sv
// Directed and randomised checks of adap_sped_seq against hand values and an
// integer G.726 speed-control model.
module tb_adap_sped_seq;

    logic CLK = 1'b0;
    logic RST_N;

    always #5 CLK = ~CLK;

    adap_sped_seq_if bus ();

    adap_sped_seq dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_err    = 0;

    int m_dms, m_dml, m_ap, m_al;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int wrap(input int v, input int m);
        int r;
        r = v % m;
        if (r < 0) r += m;
        return r;
    endfunction

    function automatic int sx(input int v, input int bits);
        if (v >= (1 << (bits - 1))) return v - (1 << bits);
        return v;
    endfunction

    task automatic model_step(input int fi, input int y, input int tdp, input int tr);
        int d, ds, dl, difm, ax, ap_n;
        d    = sx(wrap(fi * 512 - m_dms, 8192), 13);
        ds   = wrap(m_dms + (d >>> 5), 4096);
        d    = sx(wrap(fi * 2048 - m_dml, 32768), 15);
        dl   = wrap(m_dml + (d >>> 7), 16384);
        d    = sx(wrap(ds * 4 - dl, 32768), 15);
        difm = (d < 0) ? -d : d;
        ax   = (y >= 1536 && difm < dl / 8 && tdp == 0) ? 0 : 1;
        d    = sx(wrap(ax * 512 - m_ap, 2048), 11);
        ap_n = tr ? 256 : wrap(m_ap + (d >>> 4), 1024);
        m_dms = ds;
        m_dml = dl;
        m_ap  = ap_n;
        m_al  = (ap_n >= 256) ? 64 : ap_n / 4;
    endtask

    task automatic model_reset();
        m_dms = 0;
        m_dml = 0;
        m_ap  = 0;
        m_al  = 0;
    endtask

    // Issue one START, scramble inputs afterwards, and wait (bounded) for DONE.
    task automatic run(input int fi, input int y, input int tdp, input int tr, output int lat);
        @(negedge CLK);
        bus.FI    = 3'(fi);
        bus.Y     = 13'(y);
        bus.TDP   = 1'(tdp);
        bus.TR    = 1'(tr);
        bus.START = 1'b1;
        @(negedge CLK);
        bus.START = 1'b0;
        bus.FI    = ~bus.FI;
        bus.Y     = ~bus.Y;
        bus.TDP   = ~bus.TDP;
        bus.TR    = ~bus.TR;
        lat = 1;
        check("busy_fa", 32'(bus.BUSY), 32'd1);
        while (bus.DONE !== 1'b1 && lat < 20) begin
            @(negedge CLK);
            lat++;
        end
    endtask

    task automatic check_outs(input string tag, input int dms, input int dml, input int ap,
                              input int al);
        check({tag, "_dms"}, 32'(bus.DMS), 32'(dms));
        check({tag, "_dml"}, 32'(bus.DML), 32'(dml));
        check({tag, "_ap"},  32'(bus.AP),  32'(ap));
        check({tag, "_al"},  32'(bus.AL),  32'(al));
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST_N = 1'b0;
        @(negedge CLK);
        RST_N = 1'b1;
        model_reset();
    endtask

    initial begin
        int lat;
        int dones;
        int fi, y, tdp, tr;

        RST_N     = 1'b0;
        bus.START = 1'b0;
        bus.FI    = '0;
        bus.Y     = '0;
        bus.TDP   = 1'b0;
        bus.TR    = 1'b0;
        model_reset();
        repeat (2) @(negedge CLK);
        check_outs("reset", 0, 0, 0, 0);
        check("reset_busy", 32'(bus.BUSY), 32'd0);
        check("reset_done", 32'(bus.DONE), 32'd0);
        RST_N = 1'b1;

        // First update from zero state.
        run(7, 0, 0, 0, lat);
        check("lat1", 32'(lat), 32'd5);
        check_outs("fi7", 112, 112, 32, 8);
        @(negedge CLK);
        check("idle_busy", 32'(bus.BUSY), 32'd0);
        check("idle_done", 32'(bus.DONE), 32'd0);

        // Decay with FI=0: DIF=8080 -> DIFSX=-4.
        run(0, 0, 0, 0, lat);
        check("lat2", 32'(lat), 32'd5);
        check_outs("fi0", 108, 111, 62, 15);

        // Transition flag forces AP=256.
        run(5, 4000, 1, 1, lat);
        check("lat_tr", 32'(lat), 32'd5);
        check("tr_ap", 32'(bus.AP), 32'd256);
        check("tr_al", 32'(bus.AL), 32'd64);
        check("tr_dms", 32'(bus.DMS), 32'd184);
        check("tr_dml", 32'(bus.DML), 32'd190);

        // Outputs hold between updates despite input activity.
        @(negedge CLK);
        bus.FI = 3'd2;
        bus.Y  = 13'd5000;
        repeat (3) @(negedge CLK);
        check_outs("hold", 184, 190, 256, 64);

        // START held high through FA..WB gives one update only.
        do_reset();
        @(negedge CLK);
        bus.FI    = 3'd7;
        bus.Y     = 13'd0;
        bus.TDP   = 1'b0;
        bus.TR    = 1'b0;
        bus.START = 1'b1;
        dones = 0;
        lat   = 0;
        for (int i = 1; i <= 5; i++) begin
            @(negedge CLK);
            if (bus.DONE === 1'b1) begin
                dones++;
                lat = i;
            end
        end
        check_outs("restart", 112, 112, 32, 8);
        @(negedge CLK);
        bus.START = 1'b0;
        for (int i = 0; i < 7; i++) begin
            if (bus.DONE === 1'b1) dones++;
            @(negedge CLK);
        end
        check("restart_dones", 32'(dones), 32'd1);
        check("restart_lat", 32'(lat), 32'd5);
        check_outs("restart_after", 112, 112, 32, 8);

        // Reset asserted in SC abandons the update.
        @(negedge CLK);
        bus.FI    = 3'd3;
        bus.Y     = 13'd2000;
        bus.START = 1'b1;
        @(negedge CLK);
        bus.START = 1'b0;
        repeat (2) @(negedge CLK);
        RST_N = 1'b0;
        #1;
        check_outs("midrst", 0, 0, 0, 0);
        check("midrst_busy", 32'(bus.BUSY), 32'd0);
        check("midrst_done", 32'(bus.DONE), 32'd0);
        @(negedge CLK);
        RST_N = 1'b1;
        dones = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            if (bus.DONE === 1'b1) dones++;
        end
        check("midrst_nodone", 32'(dones), 32'd0);
        check_outs("midrst_hold", 0, 0, 0, 0);
        run(7, 0, 0, 0, lat);
        check("midrst_lat", 32'(lat), 32'd5);
        check_outs("midrst_next", 112, 112, 32, 8);

        // Randomised run against the reference model.
        do_reset();
        fi = 0;
        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(0, 7) == 0) fi = int'($urandom_range(0, 7));
            y   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 1535))
                                              : int'($urandom_range(1536, 8191));
            tdp = ($urandom_range(0, 15) == 0) ? 1 : 0;
            tr  = ($urandom_range(0, 31) == 0) ? 1 : 0;
            model_step(fi, y, tdp, tr);
            run(fi, y, tdp, tr, lat);
            check("rand_lat", 32'(lat), 32'd5);
            check_outs("rand", m_dms, m_dml, m_ap, m_al);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
